// File: rtl/i2c_req_arbiter.sv
// -----------------------------------------------------------------------------
// i2c_req_arbiter
//
// Shares one byte-oriented I2C master between NREQ requesters. A round-robin
// arbiter picks one pending request, grants it, and hands its slave address,
// direction and write byte to the master. It then waits for the master to
// finish, or gives up after TIMEOUT_CYC cycles, and returns the outcome to
// the granted requester.
//
// Parameters
//   NREQ        number of requester ports (2..8)
//   TIMEOUT_CYC clk cycles allowed between command issue and m_done
//
// Ports
//   clk, rst     clock (rising edge) and synchronous active-high reset
//   req          per-requester request level
//   req_addr     7-bit slave address per requester, slice i = [7i+6:7i]
//   req_rw       per-requester direction, 1 = read
//   req_wdata    write byte per requester, slice i = [8i+7:8i]
//   gnt          one-hot, one-cycle grant pulse
//   rsp_valid    one-hot, one-cycle completion pulse
//   rsp_rdata    read byte (8'h00 for writes and timeouts)
//   rsp_err      ack error, forced to 1 on timeout
//   rsp_timeout  master did not finish within TIMEOUT_CYC cycles
//   m_newd       command strobe to the master
//   m_addr/m_op/m_din  command operands, held from issue until the response
//   m_busy, m_done, m_ack_err, m_dout  status and read data from the master
//
// Timing (all outputs are registered):
//   gnt visible in cycle T, m_newd in T+1, rsp_valid in the cycle after the
//   one in which m_done is sampled, next gnt at least one cycle later.
// -----------------------------------------------------------------------------
module i2c_req_arbiter #(
    parameter int NREQ        = 4,
    parameter int TIMEOUT_CYC = 400000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NREQ-1:0]     req,
    input  logic [NREQ*7-1:0]   req_addr,
    input  logic [NREQ-1:0]     req_rw,
    input  logic [NREQ*8-1:0]   req_wdata,
    output logic [NREQ-1:0]     gnt,
    output logic [NREQ-1:0]     rsp_valid,
    output logic [7:0]          rsp_rdata,
    output logic                rsp_err,
    output logic                rsp_timeout,
    output logic                m_newd,
    output logic [6:0]          m_addr,
    output logic                m_op,
    output logic [7:0]          m_din,
    input  logic                m_busy,
    input  logic                m_done,
    input  logic                m_ack_err,
    input  logic [7:0]          m_dout
);

    localparam int IDX_W = $clog2(NREQ);
    localparam int CNT_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;

    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_TERM = CNT_W'(TIMEOUT_CYC - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NREQ - 1);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        WAIT_DONE = 2'd2,
        RESP      = 2'd3
    } state_t;

    // Round-robin pick: first set request bit after 'last', wrapping at NREQ-1.
    function automatic logic [IDX_W-1:0] rr_pick(
        input logic [NREQ-1:0]  r,
        input logic [IDX_W-1:0] last
    );
        logic [IDX_W-1:0] cand;
        logic [IDX_W-1:0] pick;
        logic             found;
        cand  = last;
        pick  = last;
        found = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            if (cand == IDX_LAST) begin
                cand = {IDX_W{1'b0}};
            end else begin
                cand = cand + IDX_W'(1);
            end
            if (!found && r[cand]) begin
                pick  = cand;
                found = 1'b1;
            end else begin
                found = found;
            end
        end
        return pick;
    endfunction

    function automatic logic [NREQ-1:0] to_onehot(input logic [IDX_W-1:0] i);
        return {{(NREQ-1){1'b0}}, 1'b1} << i;
    endfunction

    // Unpacked views of the flat per-requester operand buses.
    logic [6:0] addr_arr_s  [NREQ];
    logic [7:0] wdata_arr_s [NREQ];

    for (genvar g = 0; g < NREQ; g++) begin : g_unpack
        assign addr_arr_s[g]  = req_addr[7*g+6 : 7*g];
        assign wdata_arr_s[g] = req_wdata[8*g+7 : 8*g];
    end

    state_t            state_r,       state_nxt_s;
    logic [IDX_W-1:0]  last_r,        last_nxt_s;
    logic [IDX_W-1:0]  idx_r,         idx_nxt_s;
    logic [6:0]        lat_addr_r,    lat_addr_nxt_s;
    logic              lat_rw_r,      lat_rw_nxt_s;
    logic [7:0]        lat_wdata_r,   lat_wdata_nxt_s;
    logic [CNT_W-1:0]  cnt_r,         cnt_nxt_s;
    logic [NREQ-1:0]   gnt_r,         gnt_nxt_s;
    logic [NREQ-1:0]   rsp_valid_r,   rsp_valid_nxt_s;
    logic [7:0]        rsp_rdata_r,   rsp_rdata_nxt_s;
    logic              rsp_err_r,     rsp_err_nxt_s;
    logic              rsp_timeout_r, rsp_timeout_nxt_s;
    logic              m_newd_r,      m_newd_nxt_s;
    logic [6:0]        m_addr_r,      m_addr_nxt_s;
    logic              m_op_r,        m_op_nxt_s;
    logic [7:0]        m_din_r,       m_din_nxt_s;
    logic [IDX_W-1:0]  win_s;

    assign win_s = rr_pick(req, last_r);

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state and next-value logic for every registered output and latch.
    always_comb begin
        state_nxt_s       = state_r;
        last_nxt_s        = last_r;
        idx_nxt_s         = idx_r;
        lat_addr_nxt_s    = lat_addr_r;
        lat_rw_nxt_s      = lat_rw_r;
        lat_wdata_nxt_s   = lat_wdata_r;
        cnt_nxt_s         = cnt_r;
        gnt_nxt_s         = {NREQ{1'b0}};
        rsp_valid_nxt_s   = {NREQ{1'b0}};
        rsp_rdata_nxt_s   = rsp_rdata_r;
        rsp_err_nxt_s     = rsp_err_r;
        rsp_timeout_nxt_s = rsp_timeout_r;
        m_newd_nxt_s      = 1'b0;
        m_addr_nxt_s      = m_addr_r;
        m_op_nxt_s        = m_op_r;
        m_din_nxt_s       = m_din_r;

        case (state_r)
            IDLE: begin
                // A busy master blocks granting so a command is never dropped.
                if ((|req) && !m_busy) begin
                    state_nxt_s     = ISSUE;
                    gnt_nxt_s       = to_onehot(win_s);
                    idx_nxt_s       = win_s;
                    lat_addr_nxt_s  = addr_arr_s[win_s];
                    lat_rw_nxt_s    = req_rw[win_s];
                    lat_wdata_nxt_s = wdata_arr_s[win_s];
                end else begin
                    state_nxt_s = IDLE;
                end
            end

            ISSUE: begin
                state_nxt_s  = WAIT_DONE;
                m_newd_nxt_s = 1'b1;
                m_addr_nxt_s = lat_addr_r;
                m_op_nxt_s   = lat_rw_r;
                m_din_nxt_s  = lat_wdata_r;
                cnt_nxt_s    = CNT_ZERO;
            end

            WAIT_DONE: begin
                // m_done is checked first so it wins over the terminal count.
                if (m_done) begin
                    state_nxt_s       = RESP;
                    rsp_valid_nxt_s   = to_onehot(idx_r);
                    rsp_rdata_nxt_s   = lat_rw_r ? m_dout : 8'h00;
                    rsp_err_nxt_s     = m_ack_err;
                    rsp_timeout_nxt_s = 1'b0;
                end else if (cnt_r == CNT_TERM) begin
                    state_nxt_s       = RESP;
                    rsp_valid_nxt_s   = to_onehot(idx_r);
                    rsp_rdata_nxt_s   = 8'h00;
                    rsp_err_nxt_s     = 1'b1;
                    rsp_timeout_nxt_s = 1'b1;
                end else begin
                    cnt_nxt_s = cnt_r + CNT_ONE;
                end
            end

            RESP: begin
                // rsp_valid is high during this cycle; clear payload on exit.
                state_nxt_s       = IDLE;
                last_nxt_s        = idx_r;
                rsp_rdata_nxt_s   = 8'h00;
                rsp_err_nxt_s     = 1'b0;
                rsp_timeout_nxt_s = 1'b0;
            end

            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // Datapath, arbitration history and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_r        <= IDX_LAST;
            idx_r         <= {IDX_W{1'b0}};
            lat_addr_r    <= 7'h00;
            lat_rw_r      <= 1'b0;
            lat_wdata_r   <= 8'h00;
            cnt_r         <= CNT_ZERO;
            gnt_r         <= {NREQ{1'b0}};
            rsp_valid_r   <= {NREQ{1'b0}};
            rsp_rdata_r   <= 8'h00;
            rsp_err_r     <= 1'b0;
            rsp_timeout_r <= 1'b0;
            m_newd_r      <= 1'b0;
            m_addr_r      <= 7'h00;
            m_op_r        <= 1'b0;
            m_din_r       <= 8'h00;
        end else begin
            last_r        <= last_nxt_s;
            idx_r         <= idx_nxt_s;
            lat_addr_r    <= lat_addr_nxt_s;
            lat_rw_r      <= lat_rw_nxt_s;
            lat_wdata_r   <= lat_wdata_nxt_s;
            cnt_r         <= cnt_nxt_s;
            gnt_r         <= gnt_nxt_s;
            rsp_valid_r   <= rsp_valid_nxt_s;
            rsp_rdata_r   <= rsp_rdata_nxt_s;
            rsp_err_r     <= rsp_err_nxt_s;
            rsp_timeout_r <= rsp_timeout_nxt_s;
            m_newd_r      <= m_newd_nxt_s;
            m_addr_r      <= m_addr_nxt_s;
            m_op_r        <= m_op_nxt_s;
            m_din_r       <= m_din_nxt_s;
        end
    end

    assign gnt         = gnt_r;
    assign rsp_valid   = rsp_valid_r;
    assign rsp_rdata   = rsp_rdata_r;
    assign rsp_err     = rsp_err_r;
    assign rsp_timeout = rsp_timeout_r;
    assign m_newd      = m_newd_r;
    assign m_addr      = m_addr_r;
    assign m_op        = m_op_r;
    assign m_din       = m_din_r;

endmodule

// File: tb/tb_i2c_req_arbiter.sv
// -----------------------------------------------------------------------------
// tb_i2c_req_arbiter
//
// Directed bench for i2c_req_arbiter (NREQ=4, TIMEOUT_CYC=16). The bench plays
// both the requesters and the I2C master. Inputs change 1 time unit after a
// rising edge and outputs are sampled at that same point, so every check
// sees settled registered outputs.
// -----------------------------------------------------------------------------
module tb_i2c_req_arbiter;

    localparam int NREQ = 4;
    localparam int TO   = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  req = 4'h0;
    logic [27:0] req_addr = 28'h0;
    logic [3:0]  req_rw = 4'h0;
    logic [31:0] req_wdata = 32'h0;
    logic [3:0]  gnt;
    logic [3:0]  rsp_valid;
    logic [7:0]  rsp_rdata;
    logic        rsp_err;
    logic        rsp_timeout;
    logic        m_newd;
    logic [6:0]  m_addr;
    logic        m_op;
    logic [7:0]  m_din;
    logic        m_busy = 1'b0;
    logic        m_done = 1'b0;
    logic        m_ack_err = 1'b0;
    logic [7:0]  m_dout = 8'h00;

    int n_vec = 0;
    int n_bad = 0;

    i2c_req_arbiter #(.NREQ(NREQ), .TIMEOUT_CYC(TO)) dut (
        .clk(clk), .rst(rst), .req(req), .req_addr(req_addr), .req_rw(req_rw),
        .req_wdata(req_wdata), .gnt(gnt), .rsp_valid(rsp_valid),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
        .m_newd(m_newd), .m_addr(m_addr), .m_op(m_op), .m_din(m_din),
        .m_busy(m_busy), .m_done(m_done), .m_ack_err(m_ack_err), .m_dout(m_dout)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, %0d vectors so far", n_vec);
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ops(input int i, input logic [6:0] a, input logic rw, input logic [7:0] d);
        req_addr[i*7 +: 7]  = a;
        req_rw[i]           = rw;
        req_wdata[i*8 +: 8] = d;
    endtask

    // Wait (bounded) for a grant, then compare it.
    task automatic wait_gnt(input string tag, input logic [3:0] exp);
        int n;
        n = 0;
        do begin
            tick();
            n++;
        end while (gnt == 4'b0000 && n < 20);
        chk(tag, gnt, exp);
    endtask

    // Called in the grant cycle; plays the master and checks the whole response.
    task automatic complete(input logic [3:0] eh, input logic [6:0] ea, input logic eop,
                            input logic [7:0] ed, input int dly, input logic [7:0] dout,
                            input logic aerr);
        tick();
        chk("m_newd", m_newd, 1'b1);
        chk("gnt_pulse", gnt, 4'b0000);
        chk("m_addr", m_addr, ea);
        chk("m_op", m_op, eop);
        chk("m_din", m_din, ed);
        m_busy = 1'b1;
        repeat (dly) tick();
        chk("addr_hold", m_addr, ea);
        m_done    = 1'b1;
        m_dout    = dout;
        m_ack_err = aerr;
        tick();
        chk("rsp_valid", rsp_valid, eh);
        chk("rsp_rdata", rsp_rdata, eop ? dout : 8'h00);
        chk("rsp_err", rsp_err, aerr);
        chk("rsp_timeout", rsp_timeout, 1'b0);
        chk("din_hold", m_din, ed);
        m_done    = 1'b0;
        m_ack_err = 1'b0;
        m_busy    = 1'b0;
        m_dout    = 8'h00;
        tick();
        chk("rsp_pulse", rsp_valid, 4'b0000);
    endtask

    initial begin
        int          n;
        logic [3:0]  seen;
        logic [3:0]  oh;
        logic [1:0]  w;

        // Reset state
        repeat (3) tick();
        chk("rst_gnt", gnt, 4'b0000);
        chk("rst_rsp_valid", rsp_valid, 4'b0000);
        chk("rst_m_newd", m_newd, 1'b0);
        chk("rst_m_addr", m_addr, 7'h00);
        chk("rst_rsp_err", rsp_err, 1'b0);
        rst = 1'b0;

        // Fairness: all four requesters held high for eight transactions
        for (int i = 0; i < 4; i++) begin
            set_ops(i, 7'h10 + 7'(i), i[0], 8'hA0 + 8'(i));
        end
        req = 4'b1111;
        for (int k = 0; k < 8; k++) begin
            w  = 2'(k % 4);
            oh = 4'b0001 << w;
            wait_gnt($sformatf("rr_gnt%0d", k), oh);
            complete(oh, 7'h10 + 7'(w), w[0], 8'hA0 + 8'(w), k % 3, 8'hC0 + 8'(k), 1'b0);
        end
        req = 4'b0000;

        // Single write on requester 2, exact one-edge grant latency
        set_ops(2, 7'h50, 1'b0, 8'hA5);
        req = 4'b0100;
        tick();
        chk("wr_gnt", gnt, 4'b0100);
        req = 4'b0000;
        complete(4'b0100, 7'h50, 1'b0, 8'hA5, 2, 8'hEE, 1'b0);

        // Read on requester 0
        set_ops(0, 7'h21, 1'b1, 8'h00);
        req = 4'b0001;
        wait_gnt("rd_gnt", 4'b0001);
        req = 4'b0000;
        complete(4'b0001, 7'h21, 1'b1, 8'h00, 1, 8'h3C, 1'b0);

        // After serving 0, search starts at 1: requester 3 beats 0; ack error
        set_ops(3, 7'h33, 1'b0, 8'h5C);
        req = 4'b1001;
        wait_gnt("rr_skip", 4'b1000);
        req = 4'b0001;
        complete(4'b1000, 7'h33, 1'b0, 8'h5C, 0, 8'h00, 1'b1);
        wait_gnt("rr_next", 4'b0001);
        req = 4'b0000;
        complete(4'b0001, 7'h21, 1'b1, 8'h00, 0, 8'h99, 1'b0);

        // Timeout: master never finishes
        set_ops(1, 7'h6B, 1'b1, 8'h00);
        req = 4'b0010;
        wait_gnt("to_gnt", 4'b0010);
        req = 4'b0000;
        tick();
        chk("to_newd", m_newd, 1'b1);
        m_busy = 1'b1;
        m_dout = 8'hFF;
        n = 0;
        do begin
            tick();
            n++;
        end while (rsp_valid == 4'b0000 && n < 40);
        chk("to_latency", n, 16);
        chk("to_valid", rsp_valid, 4'b0010);
        chk("to_flag", rsp_timeout, 1'b1);
        chk("to_err", rsp_err, 1'b1);
        chk("to_rdata", rsp_rdata, 8'h00);
        m_busy = 1'b0;
        m_dout = 8'h00;
        tick();
        chk("to_clear", rsp_valid, 4'b0000);

        // m_done coincident with the terminal count wins
        req = 4'b0010;
        wait_gnt("co_gnt", 4'b0010);
        req = 4'b0000;
        tick();
        chk("co_newd", m_newd, 1'b1);
        m_busy = 1'b1;
        repeat (15) tick();
        chk("co_quiet", rsp_valid, 4'b0000);
        m_done = 1'b1;
        m_dout = 8'h5A;
        tick();
        chk("co_valid", rsp_valid, 4'b0010);
        chk("co_flag", rsp_timeout, 1'b0);
        chk("co_err", rsp_err, 1'b0);
        chk("co_rdata", rsp_rdata, 8'h5A);
        m_done = 1'b0;
        m_busy = 1'b0;
        m_dout = 8'h00;
        tick();

        // Busy gate: no grant while the master is busy
        m_busy = 1'b1;
        req    = 4'b0001;
        seen   = 4'b0000;
        repeat (5) begin
            tick();
            seen = seen | gnt;
        end
        chk("busy_gate", seen, 4'b0000);
        m_busy = 1'b0;
        tick();
        chk("busy_release", gnt, 4'b0001);
        req = 4'b0000;
        complete(4'b0001, 7'h21, 1'b1, 8'h00, 0, 8'h44, 1'b0);

        // Reset while waiting on the master; last served was 0
        set_ops(2, 7'h2A, 1'b0, 8'h7E);
        req = 4'b0100;
        wait_gnt("rs_gnt", 4'b0100);
        req = 4'b0000;
        tick();
        chk("rs_newd", m_newd, 1'b1);
        m_busy = 1'b1;
        repeat (2) tick();
        chk("rs_addr_pre", m_addr, 7'h2A);
        rst    = 1'b1;
        m_done = 1'b1;
        tick();
        chk("rs_gnt0", gnt, 4'b0000);
        chk("rs_valid0", rsp_valid, 4'b0000);
        chk("rs_rdata0", rsp_rdata, 8'h00);
        chk("rs_err0", rsp_err, 1'b0);
        chk("rs_to0", rsp_timeout, 1'b0);
        chk("rs_newd0", m_newd, 1'b0);
        chk("rs_addr0", m_addr, 7'h00);
        chk("rs_op0", m_op, 1'b0);
        chk("rs_din0", m_din, 8'h00);
        m_done = 1'b0;
        m_busy = 1'b0;
        req    = 4'b1001;
        rst    = 1'b0;
        tick();
        chk("rs_first", gnt, 4'b0001);
        chk("rs_norsp", rsp_valid, 4'b0000);
        req = 4'b1000;
        complete(4'b0001, 7'h21, 1'b1, 8'h00, 0, 8'h12, 1'b0);
        wait_gnt("rs_then3", 4'b1000);
        req = 4'b0000;
        complete(4'b1000, 7'h33, 1'b0, 8'h5C, 0, 8'h00, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/i2c_req_arbiter.md
I2C_REQ_ARBITER -- requirements
Module: i2c_req_arbiter

Interface
REQ-001 Parameter NREQ SHALL default 4 and set the number of requester ports (range 2..8).
REQ-002 Parameter TIMEOUT_CYC SHALL default 400000 and set the number of clk cycles allowed between command issue and m_done.
REQ-003 Port clk SHALL be an input, 1 bit, the system clock; all logic is on its rising edge.
REQ-004 Port rst SHALL be an input, 1 bit, reset: synchronous, active-high.
REQ-005 Port req SHALL be an input, NREQ bits, per-requester transaction request, level.
REQ-006 Port req_addr SHALL be an input, NREQ*7 bits, 7-bit slave address per requester; slice i is bits [7i+6:7i].
REQ-007 Port req_rw SHALL be an input, NREQ bits, per-requester direction: 1 = read, 0 = write.
REQ-008 Port req_wdata SHALL be an input, NREQ*8 bits, write byte per requester; slice i is bits [8i+7:8i].
REQ-009 Port gnt SHALL be an output, NREQ bits, one-hot, one-cycle grant pulse.
REQ-010 Port rsp_valid SHALL be an output, NREQ bits, one-hot, one-cycle completion pulse.
REQ-011 Ports rsp_rdata (output, 8 bits), rsp_err (output, 1 bit) and rsp_timeout (output, 1 bit) SHALL carry the read byte, the ack error and the timeout flag; they are valid while any rsp_valid bit is 1.
REQ-012 Ports m_newd (output, 1 bit, command strobe), m_addr (output, 7 bits), m_op (output, 1 bit, 1 = read) and m_din (output, 8 bits) SHALL drive the shared I2C master.
REQ-013 Ports m_busy, m_done and m_ack_err (inputs, 1 bit each) and m_dout (input, 8 bits) SHALL return status and read data from the master.

Function
REQ-014 The FSM SHALL have states IDLE, ISSUE, WAIT_DONE and RESP, one state register, and leave IDLE only as stated below.
REQ-015 IDLE: when |req==1 and m_busy==0, the block SHALL select a winner, pulse gnt[winner] for exactly one cycle, latch the winner's addr/rw/wdata and the winner index, and go to ISSUE on the next edge.
REQ-016 Arbitration SHALL be round-robin: search starts at index (last_served+1) mod NREQ and takes the first set req bit; last_served resets to NREQ-1, so req[0] has first priority after reset.
REQ-017 IDLE with m_busy==1 SHALL issue no grant, even when requests are pending.
REQ-018 ISSUE SHALL assert m_newd for exactly one cycle, with m_addr, m_op and m_din driven from the latched values, clear the timeout counter, and go to WAIT_DONE.
REQ-019 m_addr, m_op and m_din SHALL hold their latched values from ISSUE until the FSM leaves RESP.
REQ-020 WAIT_DONE SHALL increment a timeout counter every cycle; on m_done==1 it SHALL capture m_dout and m_ack_err and go to RESP.
REQ-021 If the counter reaches TIMEOUT_CYC-1 without m_done, WAIT_DONE SHALL go to RESP with rsp_timeout=1, rsp_err=1 and rsp_rdata=0.
REQ-022 When m_done and the timeout terminal count occur in the same cycle, m_done SHALL take precedence and rsp_timeout SHALL be 0.
REQ-023 RESP SHALL pulse rsp_valid[latched index] for one cycle, set last_served to that index, and return to IDLE.
REQ-024 rsp_rdata SHALL equal the captured m_dout for reads and 8'h00 for writes; rsp_err SHALL equal the captured m_ack_err unless a timeout occurred.
REQ-025 Total latency SHALL be: gnt at cycle T, m_newd at T+1, rsp_valid one cycle after m_done is sampled, next gnt no earlier than one cycle after rsp_valid.
REQ-026 Requesters SHALL hold req and their operands until gnt; req dropped before gnt SHALL be ignored, and req dropped after gnt SHALL NOT abort the transaction.
REQ-027 A req still high in the cycle after rsp_valid SHALL be treated as a new request.
REQ-028 gnt and rsp_valid SHALL each have at most one bit set in any cycle.

Reset
REQ-029 On rst==1 the block SHALL set state=IDLE, last_served=NREQ-1, counter=0, and drive all of gnt, rsp_valid, rsp_rdata, rsp_err, rsp_timeout, m_newd, m_addr, m_op and m_din to 0.
REQ-030 Reset asserted mid-transaction SHALL abandon that transaction without producing rsp_valid; arbitration resumes one cycle after rst deasserts.

Verification
REQ-031 Single write: req[2]=1, addr=7'h50, rw=0, wdata=8'hA5 -> gnt=4'b0100; next cycle m_newd=1, m_addr=50, m_din=A5, m_op=0; after m_done with m_ack_err=0 -> rsp_valid=4'b0100, rsp_err=0, rsp_rdata=00.
REQ-032 Read: req[0], rw=1, master returns m_dout=8'h3C with m_done -> rsp_valid[0]=1, rsp_rdata=3C, rsp_err=0.
REQ-033 Fairness: req=4'b1111 held continuously for 8 transactions -> grant order 0,1,2,3,0,1,2,3.
REQ-034 Timeout: TIMEOUT_CYC=16, m_done never asserted -> rsp_valid exactly 16 cycles after m_newd, with rsp_timeout=1 and rsp_err=1.
REQ-035 Busy gate and collision: with m_busy=1 and req=4'b0001 -> no gnt until m_busy=0; m_done coincident with the timeout terminal count -> rsp_timeout=0.
REQ-036 Reset in WAIT_DONE -> no rsp_valid, all outputs 0, and the next request (req[0]) is granted first.
